// File: rtl/req_ack_responder_pkg.sv
// -----------------------------------------------------------------------------
// req_ack_pkg
// Shared types and sizing for the req/ack responder and its requester-side
// counterpart.
//   state_t      : responder FSM state, 2-bit encoded
//   PEND_W       : width of the outstanding-request counter
//   CNT_W        : width of the latency down-counter
//   DEF_LATENCY  : default request-to-ack latency in cycles
//   DEF_MAX_PEND : default depth of the outstanding-request queue
// -----------------------------------------------------------------------------
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ACK   = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int PEND_W       = 4;
    localparam int CNT_W        = 8;
    localparam int DEF_LATENCY  = 4;
    localparam int DEF_MAX_PEND = 4;

endpackage

// File: rtl/req_ack_responder_edge_det.sv
// -----------------------------------------------------------------------------
// req_edge_det
// Registers the request level and flags its rising edge. Shared between the
// responder and the requester side of the req/ack handshake.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset (req_q clears to 0)
//   req   : request level
//   rise  : combinational req & ~req_q; a level already high when reset is
//           released reads as a rise on the first edge
// -----------------------------------------------------------------------------
module req_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic rise
);

    logic req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req;
        end
    end

    assign rise = req & ~req_q;

endmodule

// File: rtl/req_ack_responder.sv
// -----------------------------------------------------------------------------
// req_ack_responder
// Consumer side of a level-signalled req/ack handshake. Every rising edge of
// req is queued as a pending request and answered by a one-cycle ack pulse
// LATENCY cycles after it is taken up by the countdown.
// Parameters:
//   LATENCY  : cycles from acceptance (or reload) to ack, 1..255
//   MAX_PEND : maximum outstanding unacknowledged requests, 1..15
// Ports:
//   clk      : clock, all logic on posedge
//   rst_n    : asynchronous active-low reset, synchronous release
//   req      : request level; a rise is a new request
//   hold     : freezes the latency countdown while high (COUNT only)
//   ack      : registered one-cycle acknowledge pulse
//   pend_cnt : outstanding requests, including the one being counted
//   busy     : high whenever the FSM is not IDLE
//   overflow : sticky; a rise was dropped because the queue was full
// Optional build macro:
//   REQ_ACK_RESPONDER_SVA_EN : embeds concurrent assertions on the handshake.
//   Behaviour is identical with or without it.
// -----------------------------------------------------------------------------
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int LATENCY  = DEF_LATENCY,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              hold,
    output logic              ack,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              busy,
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(LATENCY);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pend_nxt;
    logic              rise;
    logic              ack_entry;
    logic              full;
    logic              accept;
    logic              drop;

    req_edge_det u_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .rise  (rise)
    );

    // Countdown expires this edge: the FSM moves COUNT -> ACK.
    assign ack_entry = (state == COUNT) && !hold && (cnt == CNT_W'(1));

    // A full queue still takes a rise when an ack frees a slot on the same edge.
    assign full   = (pend_cnt == PEND_MAX);
    assign accept = rise && (!full || ack_entry);
    assign drop   = rise && full && !ack_entry;

    always_comb begin
        pend_nxt = pend_cnt;
        if (accept && !ack_entry) begin
            pend_nxt = pend_cnt + 1'b1;
        end else if (!accept && ack_entry) begin
            pend_nxt = pend_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_cnt <= '0;
            ack      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            ack      <= 1'b0;
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept || (pend_cnt != '0)) begin
                        state <= COUNT;
                        cnt   <= LAT_LOAD;
                    end
                end
                COUNT: begin
                    if (!hold) begin
                        if (cnt == CNT_W'(1)) begin
                            state <= ACK;
                            ack   <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ACK: begin
                    state <= GAP;
                end
                GAP: begin
                    // Rises landing in GAP are already in pend_nxt, so they
                    // restart the countdown without a detour through IDLE.
                    if (pend_nxt != '0) begin
                        state <= COUNT;
                        cnt   <= LAT_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef REQ_ACK_RESPONDER_SVA_EN
    a_ack_follows: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> strong(##[1:$] $rose(ack)))
        $info("a_ack_follows passed");
    else
        $error("a_ack_follows violated");

    a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        ack |=> !ack)
        $info("a_ack_pulse passed");
    else
        $error("a_ack_pulse violated");

    a_pend_bound: assert property (@(posedge clk) disable iff (!rst_n)
        pend_cnt <= PEND_MAX)
        $info("a_pend_bound passed");
    else
        $error("a_pend_bound violated");

    a_hold_freeze: assert property (@(posedge clk) disable iff (!rst_n)
        (hold && (state == COUNT)) |=> $stable(cnt))
        $info("a_hold_freeze passed");
    else
        $error("a_hold_freeze violated");
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// -----------------------------------------------------------------------------
// tb_req_ack_responder
// Directed bench for req_ack_responder. Four instances share clock and reset:
//   a : LATENCY=4, MAX_PEND=4  basic timing, hold, reset mid-flight
//   b : LATENCY=2, MAX_PEND=4  queueing of three spaced requests
//   c : LATENCY=8, MAX_PEND=2  overflow and coincident accept at ACK entry
//   d : LATENCY=4, MAX_PEND=4  req held low for the whole run
// Edges are at 5, 15, 25, ...; outputs are sampled on the falling edge and
// inputs change there too.
// -----------------------------------------------------------------------------
module tb_req_ack_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, hold_a, ack_a, busy_a, ovf_a;
    logic [3:0] pend_a;
    logic       req_b, hold_b, ack_b, busy_b, ovf_b;
    logic [3:0] pend_b;
    logic       req_c, hold_c, ack_c, busy_c, ovf_c;
    logic [3:0] pend_c;
    logic       req_d, hold_d, ack_d, busy_d, ovf_d;
    logic [3:0] pend_d;

    int checks = 0;
    int errors = 0;
    int ack_d_seen = 0;

    always #5 clk = ~clk;

    req_ack_responder #(.LATENCY(4), .MAX_PEND(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .hold(hold_a),
        .ack(ack_a), .pend_cnt(pend_a), .busy(busy_a), .overflow(ovf_a));

    req_ack_responder #(.LATENCY(2), .MAX_PEND(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .hold(hold_b),
        .ack(ack_b), .pend_cnt(pend_b), .busy(busy_b), .overflow(ovf_b));

    req_ack_responder #(.LATENCY(8), .MAX_PEND(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .hold(hold_c),
        .ack(ack_c), .pend_cnt(pend_c), .busy(busy_c), .overflow(ovf_c));

    req_ack_responder #(.LATENCY(4), .MAX_PEND(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .req(req_d), .hold(hold_d),
        .ack(ack_d), .pend_cnt(pend_d), .busy(busy_d), .overflow(ovf_d));

    always @(posedge clk) begin
        if (ack_d === 1'b1) ack_d_seen <= ack_d_seen + 1;
    end

    // Called at t=2 while rst_n has been low since t=1.
    task automatic test_reset();
        checks++;
        if ({ack_a, pend_a, busy_a, ovf_a} !== 7'd0) begin
            errors++; $display("FAIL reset_a: got %b want 0000000", {ack_a, pend_a, busy_a, ovf_a});
        end
        checks++;
        if ({ack_b, pend_b, busy_b, ovf_b} !== 7'd0) begin
            errors++; $display("FAIL reset_b: got %b want 0000000", {ack_b, pend_b, busy_b, ovf_b});
        end
        checks++;
        if ({ack_c, pend_c, busy_c, ovf_c} !== 7'd0) begin
            errors++; $display("FAIL reset_c: got %b want 0000000", {ack_c, pend_c, busy_c, ovf_c});
        end
        checks++;
        if ({ack_d, pend_d, busy_d, ovf_d} !== 7'd0) begin
            errors++; $display("FAIL reset_d: got %b want 0000000", {ack_d, pend_d, busy_d, ovf_d});
        end
    endtask

    // req high 2..7, accepted at edge 5; ack expected high over 45..55 only.
    task automatic test_basic();
        logic       e_ack, e_busy;
        logic [3:0] e_pend;
        int         t;
        rst_n = 1'b1;
        req_a = 1'b1;
        #5;
        req_a = 1'b0;
        #3;
        for (int s = 1; s <= 7; s++) begin
            t      = s * 10;
            e_ack  = (t == 50);
            e_pend = (t < 45) ? 4'd1 : 4'd0;
            e_busy = (t < 65);
            checks++;
            if (ack_a !== e_ack) begin
                errors++; $display("FAIL basic_ack t=%0d: got %b want %b", t, ack_a, e_ack);
            end
            checks++;
            if (pend_a !== e_pend) begin
                errors++; $display("FAIL basic_pend t=%0d: got %0d want %0d", t, pend_a, e_pend);
            end
            checks++;
            if (busy_a !== e_busy) begin
                errors++; $display("FAIL basic_busy t=%0d: got %b want %b", t, busy_a, e_busy);
            end
            if (s < 7) #10;
        end
    endtask

    // Accept at edge 0, hold over edges 2..6 -> ack at 9 instead of 4.
    // Second request at edge 3; hold over GAP edges 10..11 adds nothing,
    // so its ack comes at 15 (reload at 11, four counts).
    task automatic test_hold();
        logic       e_ack, e_busy;
        logic [3:0] e_pend;
        req_a  = 1'b1;
        hold_a = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            @(posedge clk);
            @(negedge clk);
            e_ack  = (k == 9) || (k == 15);
            e_pend = (k < 3) ? 4'd1 : (k < 9) ? 4'd2 : (k < 15) ? 4'd1 : 4'd0;
            e_busy = (k < 17);
            checks++;
            if (ack_a !== e_ack) begin
                errors++; $display("FAIL hold_ack k=%0d: got %b want %b", k, ack_a, e_ack);
            end
            checks++;
            if (pend_a !== e_pend) begin
                errors++; $display("FAIL hold_pend k=%0d: got %0d want %0d", k, pend_a, e_pend);
            end
            checks++;
            if (busy_a !== e_busy) begin
                errors++; $display("FAIL hold_busy k=%0d: got %b want %b", k, busy_a, e_busy);
            end
            req_a  = (k + 1 == 3);
            hold_a = ((k + 1 >= 2) && (k + 1 <= 6)) || (k + 1 == 10) || (k + 1 == 11);
        end
        req_a  = 1'b0;
        hold_a = 1'b0;
    endtask

    // Rises at edges 0, 2, 4 with LATENCY=2: acks at 2, 6, 10.
    task automatic test_queueing();
        logic       e_ack, e_busy;
        logic [3:0] e_pend;
        int         pend_tab [13] = '{1, 1, 1, 1, 2, 2, 1, 1, 1, 1, 0, 0, 0};
        req_b = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            e_ack  = (k == 2) || (k == 6) || (k == 10);
            e_pend = 4'(pend_tab[k]);
            e_busy = (k < 12);
            checks++;
            if (ack_b !== e_ack) begin
                errors++; $display("FAIL queue_ack k=%0d: got %b want %b", k, ack_b, e_ack);
            end
            checks++;
            if (pend_b !== e_pend) begin
                errors++; $display("FAIL queue_pend k=%0d: got %0d want %0d", k, pend_b, e_pend);
            end
            checks++;
            if (busy_b !== e_busy) begin
                errors++; $display("FAIL queue_busy k=%0d: got %b want %b", k, busy_b, e_busy);
            end
            checks++;
            if (ovf_b !== 1'b0) begin
                errors++; $display("FAIL queue_ovf k=%0d: got %b want 0", k, ovf_b);
            end
            req_b = (k + 1 == 2) || (k + 1 == 4);
        end
        req_b = 1'b0;
    endtask

    // MAX_PEND=2, LATENCY=8. Rises at 0,2 accepted; 4,6 dropped (overflow
    // from edge 4). Rise at 12 fills the queue again; rise at 18 coincides
    // with ACK entry and is accepted. Acks at 8, 18, 28, 38.
    task automatic test_overflow();
        logic       e_ack, e_busy, e_ovf;
        logic [3:0] e_pend;
        req_c = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            e_ack  = (k == 8) || (k == 18) || (k == 28) || (k == 38);
            e_pend = (k < 2) ? 4'd1 : (k < 8) ? 4'd2 : (k < 12) ? 4'd1 :
                     (k < 28) ? 4'd2 : (k < 38) ? 4'd1 : 4'd0;
            e_ovf  = (k >= 4);
            e_busy = (k < 40);
            checks++;
            if (ack_c !== e_ack) begin
                errors++; $display("FAIL ovf_ack k=%0d: got %b want %b", k, ack_c, e_ack);
            end
            checks++;
            if (pend_c !== e_pend) begin
                errors++; $display("FAIL ovf_pend k=%0d: got %0d want %0d", k, pend_c, e_pend);
            end
            checks++;
            if (ovf_c !== e_ovf) begin
                errors++; $display("FAIL ovf_flag k=%0d: got %b want %b", k, ovf_c, e_ovf);
            end
            checks++;
            if (busy_c !== e_busy) begin
                errors++; $display("FAIL ovf_busy k=%0d: got %b want %b", k, busy_c, e_busy);
            end
            req_c = (k + 1 == 2) || (k + 1 == 4) || (k + 1 == 6) ||
                    (k + 1 == 12) || (k + 1 == 18);
        end
        req_c = 1'b0;
    endtask

    // Two requests pending in COUNT, 1-unit reset pulse, req held high across
    // release: exactly one ack four edges after the first post-reset edge.
    task automatic test_reset_mid();
        logic       e_ack, e_busy;
        logic [3:0] e_pend;
        req_a = 1'b1;
        @(posedge clk); @(negedge clk);
        req_a = 1'b0;
        @(posedge clk); @(negedge clk);
        req_a = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (pend_a !== 4'd2 || busy_a !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: got pend=%0d busy=%b want pend=2 busy=1", pend_a, busy_a);
        end
        checks++;
        if (ovf_c !== 1'b1) begin
            errors++; $display("FAIL rmid_ovf_sticky: got %b want 1", ovf_c);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack_a, pend_a, busy_a, ovf_a} !== 7'd0) begin
            errors++; $display("FAIL rmid_clear: got %b want 0000000", {ack_a, pend_a, busy_a, ovf_a});
        end
        checks++;
        if (ovf_c !== 1'b0) begin
            errors++; $display("FAIL rmid_ovf_clear: got %b want 0", ovf_c);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            e_ack  = (k == 4);
            e_pend = (k < 4) ? 4'd1 : 4'd0;
            e_busy = (k < 6);
            checks++;
            if (ack_a !== e_ack) begin
                errors++; $display("FAIL rmid_ack k=%0d: got %b want %b", k, ack_a, e_ack);
            end
            checks++;
            if (pend_a !== e_pend) begin
                errors++; $display("FAIL rmid_pend k=%0d: got %0d want %0d", k, pend_a, e_pend);
            end
            checks++;
            if (busy_a !== e_busy) begin
                errors++; $display("FAIL rmid_busy k=%0d: got %b want %b", k, busy_a, e_busy);
            end
            req_a = 1'b0;
        end
    endtask

    task automatic test_never_ack();
        checks++;
        if (ack_d_seen !== 0) begin
            errors++; $display("FAIL never_ack: got %0d ack cycles want 0", ack_d_seen);
        end
        checks++;
        if ({pend_d, busy_d, ovf_d} !== 6'd0) begin
            errors++; $display("FAIL never_state: got %b want 000000", {pend_d, busy_d, ovf_d});
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        req_a  = 1'b0; hold_a = 1'b0;
        req_b  = 1'b0; hold_b = 1'b0;
        req_c  = 1'b0; hold_c = 1'b0;
        req_d  = 1'b0; hold_d = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_hold();
        test_queueing();
        test_overflow();
        test_reset_mid();
        test_never_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_ack_responder.md
Name: req_ack_responder

Overview:
- Downstream responder for a level-signalled req/ack handshake.
- Detects each rising edge of req and queues it as a pending request.
- Answers each accepted request with a one-cycle ack pulse a programmable number of cycles later, so every accepted $rose(req) is followed by a $rose(ack).
- Sits directly on the consumer side of the req/ack interface; provides the ack source that the handshake's eventual-acknowledge property checks against.

Parameters:
- LATENCY, 4, cycles from req-edge acceptance (or reload) to ack assertion; legal 1..255.
- MAX_PEND, 4, maximum outstanding unacknowledged requests; legal 1..15.

Ports:
- clk  input  1  single clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  request level; a rise is a new request
- hold  input  1  freezes the latency countdown while high
- ack  output  1  one-cycle acknowledge pulse, registered
- pend_cnt  output  4  outstanding requests, including the one being counted
- busy  output  1  high whenever state is not IDLE
- overflow  output  1  sticky; set when a rise arrives while pend_cnt==MAX_PEND

Behaviour:
- Reset (async assert, sync release):
  - ack=0, pend_cnt=0, busy=0, overflow=0.
  - Internal req_q=0 and state=IDLE.
- Edge detect:
  - rise = req & ~req_q, evaluated at each posedge; req_q <= req.
  - req already high at reset release counts as a rise on the first edge.
- States and transitions:
  - IDLE -> COUNT on rise (or on pend_cnt>0). Loads cnt=LATENCY.
  - COUNT: cnt decrements on each edge with hold=0. When cnt==1 and hold=0 -> ACK.
  - ACK: ack=1 for exactly one cycle; pend_cnt decrements on entry. Always -> GAP.
  - GAP: ack=0 for at least one cycle. Then -> COUNT (reload LATENCY) if pend_cnt>0, else -> IDLE.
- Latency and spacing:
  - A rise accepted at edge N from IDLE gives ack high from edge N+LATENCY to N+LATENCY+1 when hold stays 0.
  - Back-to-back acks are separated by LATENCY+1 low cycles minimum.
  - Each hold cycle in COUNT adds exactly one cycle of delay. hold is ignored in IDLE, ACK and GAP.
- pend_cnt:
  - +1 on an accepted rise; -1 on ACK entry.
  - Simultaneous accept and ACK entry: unchanged.
- Full: a rise with pend_cnt==MAX_PEND and no simultaneous ACK entry is dropped and sets overflow. A rise coinciding with ACK entry is accepted.
- overflow clears only on reset.
- Reset mid-operation clears everything immediately. An ack in flight is truncated; no ack follows for requests pending at reset.

Optional Feature:
- Macro: REQ_ACK_RESPONDER_SVA_EN.
- Defined: embedded concurrent assertions, all disabled iff !rst_n:
  - every accepted rise |-> strong(##[1:$] $rose(ack));
  - ack |=> !ack;
  - pend_cnt <= MAX_PEND;
  - hold && state==COUNT |=> cnt unchanged.
  - Each assertion has an $info on pass and an $error on fail.
- Undefined: no assertion code; RTL behaviour is identical.

Decomposition:
- Package req_ack_pkg holds:
  - state_t enum {IDLE, COUNT, ACK, GAP}, 2-bit encoded;
  - PEND_W=4 and CNT_W=8;
  - DEF_LATENCY=4.
- One sub-module, req_edge_det: registers req_q and outputs rise. It is reused by the requester side.

Test Plan:
- Basic: LATENCY=4, clk period 10, req high 2-7 ns.
  - Rise accepted at edge 5 ns.
  - ack high for 45-55 ns only; pend_cnt goes 1 -> 0 at 45 ns.
  - busy low by 65 ns.
- Queueing: three req pulses two cycles apart, LATENCY=2.
  - Three acks, each separated by at least 3 low cycles.
  - pend_cnt peaks at 2 or 3; overflow stays 0.
- Overflow: MAX_PEND=2, four rises before the first ack.
  - overflow=1 after the third rise and only two acks.
  - A coincident rise at ACK entry is still accepted.
- Hold: hold high for 5 cycles mid-COUNT.
  - ack arrives exactly 5 cycles later than the no-hold case.
  - hold asserted in GAP causes no delay.
- Reset mid-flight: rst_n low for 1 ns during COUNT with pend_cnt=2.
  - All outputs 0 immediately; no ack afterwards.
  - req held high across release produces one new ack after LATENCY.
- Never acknowledged: req held low for the whole run.
  - ack never rises; with REQ_ACK_RESPONDER_SVA_EN the eventuality property stays vacuous, with no failure at $finish.
